// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage data memory request/response bundle
interface dmem_responder_if;
    logic        MemReadMEM;
    logic        MemWriteMEM;
    logic [31:0] ALUresultMEM;
    logic [31:0] dmemdata;
    logic [31:0] dmemout;
    logic        mem_stall;
    logic        mem_done;
    logic        err_misalign;

    modport master (
        output MemReadMEM, MemWriteMEM, ALUresultMEM, dmemdata,
        input  dmemout, mem_stall, mem_done, err_misalign
    );

    modport slave (
        input  MemReadMEM, MemWriteMEM, ALUresultMEM, dmemdata,
        output dmemout, mem_stall, mem_done, err_misalign
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data memory responder for the MEM stage
// Optional misaligned-access trap enabled by DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    state_t            nextState;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addrQ;
    logic [31:0]       wdataQ;
    logic              writeQ;
    logic              readQ;
    logic [31:0]       dmemoutQ;
    logic [31:0]       mem [2**ADDR_W];
    logic              req;
    logic              accessNow;
    logic              accessOk;
    logic              unusedAddrBits;

    assign req       = bus.MemReadMEM | bus.MemWriteMEM;
    assign accessNow = (state == BUSY) && (cnt == 4'd0);
    assign bus.dmemout = dmemoutQ;
    assign unusedAddrBits = ^{bus.ALUresultMEM[31:ADDR_W+2], bus.ALUresultMEM[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    logic misalignQ;
    logic errQ;

    assign accessOk         = !misalignQ;
    assign bus.err_misalign = errQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalignQ <= 1'b0;
            errQ      <= 1'b0;
        end else begin
            if (state == IDLE && req)
                misalignQ <= |bus.ALUresultMEM[1:0];
            if (accessNow && misalignQ)
                errQ <= 1'b1;
        end
    end
`else
    assign accessOk         = 1'b1;
    assign bus.err_misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState     = state;
        bus.mem_stall = 1'b0;
        bus.mem_done  = 1'b0;
        case (state)
            IDLE: begin
                bus.mem_stall = req;
                if (req)
                    nextState = BUSY;
            end
            BUSY: begin
                bus.mem_stall = 1'b1;
                if (cnt == 4'd0)
                    nextState = DONE;
            end
            DONE: begin
                bus.mem_done = 1'b1;
                nextState    = IDLE;
            end
            default: nextState = IDLE;
        endcase
        // The pipeline must never see a stall while the responder is held in reset.
        if (reset)
            bus.mem_stall = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= 4'd0;
            addrQ    <= '0;
            wdataQ   <= 32'd0;
            writeQ   <= 1'b0;
            readQ    <= 1'b0;
            dmemoutQ <= 32'd0;
        end else begin
            if (state == IDLE && req) begin
                addrQ  <= bus.ALUresultMEM[ADDR_W+1:2];
                wdataQ <= bus.dmemdata;
                writeQ <= bus.MemWriteMEM;
                readQ  <= bus.MemReadMEM;
                cnt    <= 4'(WAIT_CYCLES);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // A combined read+write returns the written data; a pure write leaves dmemout alone.
            if (accessNow && accessOk) begin
                if (writeQ) begin
                    if (readQ)
                        dmemoutQ <= wdataQ;
                end else begin
                    dmemoutQ <= mem[addrQ];
                end
            end
        end
    end

    // State is IDLE throughout reset, so an aborted access can never reach the array.
    always_ff @(posedge clk) begin
        if (accessNow && accessOk && writeQ)
            mem[addrQ] <= wdataQ;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (WAIT_CYCLES 2 and 0)
module tb_dmem_responder;
    localparam int AW = 10;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    dmem_responder_if busA ();
    dmem_responder_if busB ();

    dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) dutA (.clk(clk), .reset(reset), .bus(busA));
    dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dutB (.clk(clk), .reset(reset), .bus(busB));

    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nPass   = 0;
    logic [31:0] sbq[$];
    logic [31:0] model [2][1024];
    logic [31:0] expOut [2];
    logic        expErr [2];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp)
            nPass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic dropReq();
        busA.MemReadMEM = 1'b0; busA.MemWriteMEM = 1'b0;
        busB.MemReadMEM = 1'b0; busB.MemWriteMEM = 1'b0;
    endtask

    task automatic access(input bit b, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data);
        int          idx;
        int          stallCnt;
        int          doneCyc;
        int          waitCyc;
        logic [31:0] got;
        logic        gotErr;
        idx     = int'((addr >> 2) & 32'((1 << AW) - 1));
        waitCyc = b ? 0 : 2;
        if (ALIGN_EN && addr[1:0] != 2'b00) begin
            expErr[b] = 1'b1;
        end else if (wr) begin
            model[b][idx] = data;
            if (rd) expOut[b] = data;
        end else if (rd) begin
            expOut[b] = model[b][idx];
        end
        sbq.push_back(expOut[b]);

        @(posedge clk); #1;
        if (b) begin
            busB.MemReadMEM = rd; busB.MemWriteMEM = wr; busB.ALUresultMEM = addr; busB.dmemdata = data;
        end else begin
            busA.MemReadMEM = rd; busA.MemWriteMEM = wr; busA.ALUresultMEM = addr; busA.dmemdata = data;
        end
        stallCnt = 0;
        doneCyc  = -1;
        got      = 32'hxxxxxxxx;
        gotErr   = 1'bx;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (b ? busB.mem_stall : busA.mem_stall) stallCnt++;
            if (b ? busB.mem_done : busA.mem_done) begin
                doneCyc = c;
                got     = b ? busB.dmemout : busA.dmemout;
                gotErr  = b ? busB.err_misalign : busA.err_misalign;
                break;
            end
            @(posedge clk); #1;
            if (c == 0) dropReq();
        end
        dropReq();
        checkVal("stallCycles", 32'(stallCnt), 32'(waitCyc + 2));
        checkVal("doneCycle", 32'(doneCyc), 32'(waitCyc + 2));
        checkVal("dmemout", got, sbq.pop_front());
        checkVal("errMisalign", {31'd0, gotErr}, {31'd0, expErr[b]});
    endtask

    initial begin
        logic [2:0]  sp;
        logic [2:0]  dp;
        logic [31:0] outAtDone;

        reset = 1'b1;
        dropReq();
        busA.ALUresultMEM = 32'd0; busA.dmemdata = 32'd0;
        busB.ALUresultMEM = 32'd0; busB.dmemdata = 32'd0;
        expOut[0] = 32'd0; expOut[1] = 32'd0;
        expErr[0] = 1'b0;  expErr[1] = 1'b0;
        busA.MemReadMEM = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rstStall", {31'd0, busA.mem_stall}, 32'd0);
        checkVal("rstDone", {31'd0, busA.mem_done}, 32'd0);
        checkVal("rstDmemout", busA.dmemout, 32'd0);
        checkVal("rstErr", {31'd0, busA.err_misalign}, 32'd0);
        busA.MemReadMEM = 1'b0;
        reset = 1'b0;

        // reset aborts an in-flight write to word 5
        access(0, 1'b0, 1'b1, 32'h14, 32'h11);
        @(posedge clk); #1;
        busA.MemWriteMEM = 1'b1; busA.ALUresultMEM = 32'h14; busA.dmemdata = 32'h99;
        @(posedge clk); #1;
        dropReq();
        reset = 1'b1;
        #1;
        checkVal("stallInReset", {31'd0, busA.mem_stall}, 32'd0);
        @(negedge clk);
        checkVal("dmemoutAfterAbort", busA.dmemout, 32'd0);
        reset = 1'b0;
        expOut[0] = 32'd0; expOut[1] = 32'd0;
        access(0, 1'b1, 1'b0, 32'h14, 32'd0);

        access(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 32'h40, 32'd0);

        access(0, 1'b0, 1'b1, (32'd4 << AW) + 32'd8, 32'hA5A5A5A5);
        access(0, 1'b1, 1'b0, 32'h8, 32'd0);

        access(0, 1'b1, 1'b1, 32'h10, 32'h1234);
        access(0, 1'b1, 1'b0, 32'h10, 32'd0);

        access(0, 1'b0, 1'b1, 32'h41, 32'h77);
        access(0, 1'b1, 1'b0, 32'h40, 32'd0);

        @(posedge clk);
        @(negedge clk);
        checkVal("idleStall", {31'd0, busA.mem_stall}, 32'd0);
        checkVal("idleHold", busA.dmemout, expOut[0]);

        for (int i = 1; i <= 3; i++)
            access(1, 1'b0, 1'b1, 32'(i * 4), 32'h100 + 32'(i));

        // back-to-back reads with the request held high throughout
        @(posedge clk); #1;
        busB.MemReadMEM = 1'b1; busB.ALUresultMEM = 32'd4;
        for (int k = 0; k < 3; k++) begin
            sp = 3'b000; dp = 3'b000; outAtDone = 32'hxxxxxxxx;
            sbq.push_back(model[1][k + 1]);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                sp[2 - c] = busB.mem_stall;
                dp[2 - c] = busB.mem_done;
                if (busB.mem_done) outAtDone = busB.dmemout;
                @(posedge clk); #1;
                if (c == 2) begin
                    if (k < 2) busB.ALUresultMEM = 32'((k + 2) * 4);
                    else       busB.MemReadMEM = 1'b0;
                end
            end
            checkVal("b2bStall", {29'd0, sp}, 32'b110);
            checkVal("b2bDone", {29'd0, dp}, 32'b001);
            checkVal("b2bData", outAtDone, sbq.pop_front());
        end

        @(negedge clk);
        reset = 1'b1;
        #1;
        checkVal("errClearedByReset", {31'd0, busA.err_misalign}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
